wb_ps2_rx: RTL

Host-side PS/2 receiver with a Wishbone B4 classic slave interface. It is the receiving end of the keyboard/mouse device-to-host serial protocol on the ps2_clk/ps2_dat pins. It sits behind the peripheral arbiter next to the UART and SPI slaves. Decoded bytes are buffered in a FIFO, and an interrupt request is raised while data is pending.

---
 rtl/wb_ps2_rx.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_ps2_rx.sv
// wb_ps2_rx: host-side PS/2 receiver behind a Wishbone B4 classic slave.
// Frames from the device are filtered, deserialized, checked for parity and
// stop bit, then buffered in a byte FIFO. irq_o is high while data is pending
// and the interrupt is enabled.
//
// Receiver FSM
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | waiting for a start bit (falling edge with data low)
//   S_SHIFT | capturing data bits 1..8, parity (9), stop (10); timeout armed
//   S_CHECK | one cycle: validate the frame, push or flag
//
// Register map (word address adr_i[1:0])
//   0 DATA   rd: [8] valid, [7:0] head byte; pops when non-empty
//   1 STATUS rd: [0] ne, [1] full, [2] ovr, [3] perr, [4] ferr, [5] toerr,
//               [16:8] count; wr: W1C on [5:2]
//   2 CTRL   rd/wr: [0] rx_en, [1] irq_en; wr [2]=1 flushes the FIFO
//   3        reads 0
module wb_ps2_rx #(
    parameter int DEPTH   = 16,
    parameter int FILT    = 8,
    parameter int TIMEOUT = 100000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        cyc_i,
    input  logic        stb_i,
    input  logic        we_i,
    input  logic [29:0] adr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] dat_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic        irq_o,
    input  logic        ps2_clk,
    input  logic        ps2_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int FW = $clog2(FILT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // pin synchronizers
    logic ps2_clk_m, ps2_clk_s;
    logic ps2_dat_m, ps2_dat_s;

    // clock filter
    logic          clk_f, clk_f_q;
    logic [FW-1:0] filt_cnt;
    logic          fall;

    // receiver
    state_t        state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic          stop_bit;
    logic [TW-1:0] tmo_cnt;
    logic          timeout;

    // FIFO
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          not_empty, full;

    // bus / registers
    logic          access, rd, wr;
    logic          pop, push, flush;
    logic          in_check, par_ok, good;
    logic [3:0]    flags;       // {toerr, ferr, perr, ovr}
    logic [3:0]    flag_set;
    logic [3:0]    flag_clr;
    logic          rx_en, irq_en;
    logic [31:0]   rdata;
    logic          unused_bits;

    assign unused_bits = ^{adr_i[29:2], sel_i[3:1], dat_i[31:6]};

    // Two-flop synchronizers; idle level of both lines is high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ps2_clk_m <= 1'b1;
            ps2_clk_s <= 1'b1;
            ps2_dat_m <= 1'b1;
            ps2_dat_s <= 1'b1;
        end else begin
            ps2_clk_m <= ps2_clk;
            ps2_clk_s <= ps2_clk_m;
            ps2_dat_m <= ps2_dat;
            ps2_dat_s <= ps2_dat_m;
        end
    end

    // Filtered clock flips only after FILT consecutive differing samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_f    <= 1'b1;
            clk_f_q  <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_f_q <= clk_f;
            if (ps2_clk_s != clk_f) begin
                if (filt_cnt == FW'(FILT - 1)) begin
                    clk_f    <= ~clk_f;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall     = clk_f_q & ~clk_f;
    assign timeout  = (state == S_SHIFT) && rx_en && !fall && (tmo_cnt == '0);
    assign in_check = (state == S_CHECK);
    assign par_ok   = ^{shreg, par_bit};
    assign good     = par_ok & stop_bit;

    // Receiver FSM; the timeout timer is a down-counter reloaded on every edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bit <= 1'b0;
            tmo_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fall && !ps2_dat_s && rx_en) begin
                        state   <= S_SHIFT;
                        bit_cnt <= 4'd1;
                        tmo_cnt <= TW'(TIMEOUT - 1);
                    end
                end
                S_SHIFT: begin
                    if (!rx_en) begin
                        state <= S_IDLE;
                    end else if (fall) begin
                        tmo_cnt <= TW'(TIMEOUT - 1);
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt <= 4'd8) begin
                            shreg <= {ps2_dat_s, shreg[7:1]};
                        end else if (bit_cnt == 4'd9) begin
                            par_bit <= ps2_dat_s;
                        end else begin
                            stop_bit <= ps2_dat_s;
                            state    <= S_CHECK;
                        end
                    end else if (tmo_cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt - 1'b1;
                    end
                end
                S_CHECK: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign access    = cyc_i & stb_i & ~ack_o;
    assign rd        = access & ~we_i;
    assign wr        = access & we_i & sel_i[0];
    assign not_empty = (count != '0);
    assign full      = (count == CW'(DEPTH));
    assign pop       = rd && (adr_i[1:0] == 2'd0) && not_empty;
    assign push      = in_check & good & (~full | pop);
    assign flush     = wr && (adr_i[1:0] == 2'd2) && dat_i[2];

    assign flag_set = {timeout, in_check & ~stop_bit, in_check & ~par_ok,
                       in_check & good & full & ~pop};
    assign flag_clr = (wr && (adr_i[1:0] == 2'd1)) ? dat_i[5:2] : 4'd0;

    // FIFO storage; no reset needed, count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    // FIFO pointers and fill count; flush overrides a coincident push/pop.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a set in the same cycle as a W1C wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flags <= '0;
        end else begin
            flags <= flag_set | (flags & ~flag_clr);
        end
    end

    // Control register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_en  <= 1'b1;
            irq_en <= 1'b0;
        end else if (wr && (adr_i[1:0] == 2'd2)) begin
            rx_en  <= dat_i[0];
            irq_en <= dat_i[1];
        end
    end

    // Read data mux.
    always_comb begin
        rdata = '0;
        case (adr_i[1:0])
            2'd0: if (not_empty) rdata = {23'd0, 1'b1, mem[rd_ptr]};
            2'd1: rdata = {15'd0, 9'(count), 2'b00, flags, full, not_empty};
            2'd2: rdata = {30'd0, irq_en, rx_en};
            default: rdata = '0;
        endcase
    end

    // Single-cycle acknowledge; read data only valid alongside ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_o <= 1'b0;
            dat_o <= '0;
        end else begin
            ack_o <= access;
            dat_o <= rd ? rdata : 32'd0;
        end
    end

    // Level interrupt, one cycle behind the fill count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= irq_en & not_empty;
        end
    end

endmodule
